// File: rtl/spi_frame_receiver_if.sv
// Pin-side SPI signals and the decoded register-write bus of the SPI frame receiver.
// The master side drives the SPI pins and observes the write bus; the slave side is
// the receiver itself.
interface spi_frame_receiver_if;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;
  logic       frame_active;

  modport master (
    output sclk,
    output copi,
    output ncs,
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    input  frame_err,
    input  frame_active
  );

  modport slave (
    input  sclk,
    input  copi,
    input  ncs,
    output wr_valid,
    output wr_addr,
    output wr_data,
    output frame_err,
    output frame_active
  );
endinterface

// File: rtl/spi_frame_receiver.sv
// SPI frame receiver: synchronises raw SPI pins into the clk domain, shifts in 16-bit
// frames (R/W, 7-bit address, 8-bit data, MSB first, mode 0) and emits a one-cycle
// register write strobe for valid, in-range writes. Frames with a bad bit count raise a
// one-cycle frame_err pulse; reads and out-of-range writes are dropped silently.
module spi_frame_receiver #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_ADDR    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_frame_receiver_if.slave  bus
);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCommit
  } state_e;

  localparam logic [4:0] FrameBits = 5'd16;
  localparam logic [4:0] CountSat  = 5'd17;
  localparam logic [6:0] MaxAddr   = 7'(MAX_ADDR);

  // Synchroniser chains; the last stage is the clk-domain view of each pin.
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] copi_sync_q;
  logic [SYNC_STAGES-1:0] ncs_sync_q;
  // Walks a one through the chain length after reset, marking when ncs_s reflects the pin.
  logic [SYNC_STAGES-1:0] flush_q;

  logic sclk_s;
  logic copi_s;
  logic ncs_s;

  logic sclk_prev_q;
  logic ncs_prev_q;
  logic ncs_armed_q;

  logic sclk_rise;
  logic ncs_fall;
  logic ncs_rise;

  state_e      state_q;
  logic [15:0] shift_q;
  logic [4:0]  count_q;
  logic        wr_valid_q;
  logic [6:0]  wr_addr_q;
  logic [7:0]  wr_data_q;
  logic        frame_err_q;
  logic        frame_active_q;

  logic       len_ok;
  logic       is_write;
  logic [6:0] frame_addr;
  logic [7:0] frame_data;
  logic       in_range;

  // Pin synchronisers; ncs idles high so a reset never looks like a selected bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      flush_q     <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], bus.copi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], bus.ncs};
      flush_q     <= {flush_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];

  // Previous-value flops for edge detection, plus the nCS arming flag. A chip select
  // held low across reset release must not start a frame: the receiver only arms once
  // the synchronised pin has genuinely been seen high after the chain has flushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b1;
      ncs_armed_q <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      ncs_prev_q  <= ncs_s;
      if (flush_q[SYNC_STAGES-1] && ncs_s) begin
        ncs_armed_q <= 1'b1;
      end
    end
  end

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign ncs_fall  = ncs_armed_q & ~ncs_s & ncs_prev_q;
  assign ncs_rise  = ncs_s & ~ncs_prev_q;

  // Frame decode from the current shifter contents.
  assign len_ok     = (count_q == FrameBits);
  assign is_write   = shift_q[15];
  assign frame_addr = shift_q[14:8];
  assign frame_data = shift_q[7:0];
  assign in_range   = (frame_addr <= MaxAddr);

  // Frame FSM with registered outputs. The commit decision is taken on the nCS rise so
  // that the registered strobe/error is visible exactly during the single COMMIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      shift_q        <= '0;
      count_q        <= '0;
      wr_valid_q     <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      frame_err_q    <= 1'b0;
      frame_active_q <= 1'b0;
    end else begin
      wr_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // An SCLK rise coinciding with the nCS fall is deliberately not shifted.
          if (ncs_fall) begin
            shift_q        <= '0;
            count_q        <= '0;
            frame_active_q <= 1'b1;
            state_q        <= StShift;
          end
        end
        StShift: begin
          if (ncs_rise) begin
            frame_active_q <= 1'b0;
            state_q        <= StCommit;
            if (!len_ok) begin
              frame_err_q <= 1'b1;
            end else if (is_write && in_range) begin
              wr_valid_q <= 1'b1;
              wr_addr_q  <= frame_addr;
              wr_data_q  <= frame_data;
            end
          end else if (sclk_rise) begin
            shift_q <= {shift_q[14:0], copi_s};
            if (count_q != CountSat) begin
              count_q <= count_q + 5'd1;
            end
          end
        end
        StCommit: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.wr_valid     = wr_valid_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.frame_active = frame_active_q;

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Self-checking bench for spi_frame_receiver: directed frames from the test plan, a
// randomized frame run and a pin-level latency sweep, all checked against a frame-level
// reference model (bit count, R/W bit and address range decide the outcome).
module tb_spi_frame_receiver;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned MaxAddr    = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  spi_frame_receiver_if bus ();

  spi_frame_receiver #(
    .SYNC_STAGES(SyncStages),
    .MAX_ADDR   (MaxAddr)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Observed traffic, collected continuously.
  logic [14:0] got_q[$];
  int          got_err  = 0;
  int          dbl_cnt  = 0;
  bit          prev_valid = 1'b0;

  // Reference model state.
  logic [14:0] exp_q[$];
  int          exp_err = 0;
  logic [6:0]  last_addr = '0;
  logic [7:0]  last_data = '0;
  int          seen = 0;

  // Bus monitor: records strobes and errors, and notes any strobe lasting two cycles.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
    end else begin
      if (bus.wr_valid) begin
        got_q.push_back({bus.wr_addr, bus.wr_data});
        if (prev_valid) dbl_cnt <= dbl_cnt + 1;
      end
      if (bus.frame_err) got_err <= got_err + 1;
      prev_valid <= bus.wr_valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "simulation did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Frame-level model: only the bit count, R/W bit and address range matter.
  task automatic model_frame(input logic [31:0] bits, input int n);
    logic [15:0] w;
    if (n != 16) begin
      exp_err++;
    end else begin
      w = bits[15:0];
      if (w[15] && (int'(w[14:8]) <= int'(MaxAddr))) begin
        exp_q.push_back(w[14:0]);
        last_addr = w[14:8];
        last_data = w[7:0];
      end
    end
  endtask

  // Shift n bits MSB first, mode 0, each SCLK level lasting `half` clk cycles.
  task automatic spi_bits(input logic [31:0] bits, input int n, input int half);
    for (int i = n - 1; i >= 0; i--) begin
      bus.copi = bits[i];
      wait_clks(half);
      bus.sclk = 1'b1;
      wait_clks(half);
      bus.sclk = 1'b0;
    end
  endtask

  // Full frame; returns right after ncs rises `phase` time units past a clk edge.
  task automatic send_frame(input logic [31:0] bits, input int n, input int half,
                            input int phase);
    bus.ncs = 1'b0;
    wait_clks(half);
    spi_bits(bits, n, half);
    wait_clks(half);
    check("frame_active_mid", {31'b0, bus.frame_active}, 32'd1);
    model_frame(bits, n);
    @(posedge clk);
    #(phase);
    bus.ncs = 1'b1;
  endtask

  task automatic expect_results(input string tag);
    wait_clks(SyncStages + 6);
    check({tag, "_strobes"}, got_q.size(), exp_q.size());
    for (int i = seen; i < got_q.size() && i < exp_q.size(); i++) begin
      check({tag, "_write"}, {17'b0, got_q[i]}, {17'b0, exp_q[i]});
    end
    seen = exp_q.size();
    check({tag, "_frame_err"}, got_err, exp_err);
    check({tag, "_strobe_width"}, dbl_cnt, 0);
    check({tag, "_addr_hold"}, {25'b0, bus.wr_addr}, {25'b0, last_addr});
    check({tag, "_data_hold"}, {24'b0, bus.wr_data}, {24'b0, last_data});
    check({tag, "_frame_active_idle"}, {31'b0, bus.frame_active}, 32'd0);
  endtask

  initial begin
    int          n;
    int          half;
    int          gap;
    int          phase;
    int          lat;
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  data;
    logic [15:0] w;
    logic [31:0] bits;
    int          lens[10] = '{0, 1, 8, 15, 16, 16, 16, 16, 17, 20};

    bus.sclk = 1'b0;
    bus.copi = 1'b0;
    bus.ncs  = 1'b1;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_wr_valid", {31'b0, bus.wr_valid}, 32'd0);
    check("rst_wr_addr", {25'b0, bus.wr_addr}, 32'd0);
    check("rst_wr_data", {24'b0, bus.wr_data}, 32'd0);
    check("rst_frame_err", {31'b0, bus.frame_err}, 32'd0);
    check("rst_frame_active", {31'b0, bus.frame_active}, 32'd0);
    rst = 1'b0;
    wait_clks(SyncStages + 4);

    // Write addr 0x00 data 0xF0 at SCLK = clk/8.
    send_frame(32'h0000_80F0, 16, 4, 2);
    expect_results("write00");

    // Read frame: dropped, outputs keep the previous write.
    send_frame(32'h0000_0455, 16, 4, 2);
    expect_results("read");

    // 15-bit frame, then 17-bit frame whose first 16 bits are a valid write.
    send_frame(32'h0000_84A5 >> 1, 15, 4, 2);
    expect_results("len15");
    send_frame(32'h0001_08B5, 17, 4, 2);
    expect_results("len17");

    // Out-of-range write then a valid one, ncs high for 2 clk between them.
    send_frame(32'h0000_8511, 16, 4, 2);
    wait_clks(2);
    send_frame(32'h0000_84AA, 16, 4, 2);
    expect_results("b2b");

    // Reset after 9 bits, ncs held low across release, then 7 more bits.
    bus.ncs = 1'b0;
    wait_clks(4);
    spi_bits(32'h0000_81FF >> 7, 9, 4);
    rst = 1'b1;
    wait_clks(2);
    check("rst_mid_active", {31'b0, bus.frame_active}, 32'd0);
    rst = 1'b0;
    last_addr = '0;
    last_data = '0;
    spi_bits(32'h0000_007F, 7, 4);
    check("rst_mid_stays_idle", {31'b0, bus.frame_active}, 32'd0);
    wait_clks(2);
    bus.ncs = 1'b1;
    expect_results("rst_mid");

    send_frame(32'h0000_823C, 16, 4, 2);
    expect_results("after_rst");

    // Randomized frames: varied length, R/W, address, rate, gap and ncs phase.
    for (int it = 0; it < 24; it++) begin
      n     = lens[$urandom_range(0, 9)];
      rw    = ($urandom_range(0, 3) != 0);
      addr  = 7'($urandom_range(0, 7));
      data  = 8'($urandom);
      w     = {rw, addr, data};
      half  = $urandom_range(2, 5);
      gap   = $urandom_range(3, 6);
      phase = $urandom_range(1, 9);
      if (n >= 16) begin
        bits = ({16'b0, w} << (n - 16)) | ($urandom & ((32'd1 << (n - 16)) - 32'd1));
      end else begin
        bits = {16'b0, w} >> (16 - n);
      end
      send_frame(bits, n, half, phase);
      wait_clks(gap);
      if (it % 3 == 2) expect_results("random");
    end
    expect_results("random_end");

    // Latency: clk edges from the ncs pin rise to the edge at which the register bank
    // samples the strobe.
    for (int p = 1; p <= 9; p++) begin
      send_frame(32'h0000_8300 | p, 16, 3, p);
      lat = 0;
      for (int k = 1; k <= int'(SyncStages) + 8; k++) begin
        @(posedge clk);
        #1;
        if (bus.wr_valid) begin
          lat = k + 1;
          break;
        end
      end
      check("latency_window",
            {31'b0, (lat == int'(SyncStages) + 2) || (lat == int'(SyncStages) + 3)}, 32'd1);
      @(posedge clk);
      #1;
      check("latency_single_cycle", {31'b0, bus.wr_valid}, 32'd0);
      expect_results("latency");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
